// File: rtl/clk_en_gen_if.sv
// rtl/clk_en_gen_if.sv - divisor configuration handshake for clk_en_gen
// CLK_GEN_FRAC_EN adds the fractional increment field.
interface clk_en_gen_if #(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 2
`ifdef CLK_GEN_FRAC_EN
  ,
  parameter int FRAC_W = 8
`endif
);
  logic [NUM_CH*CNT_W-1:0]  cfg_div;
`ifdef CLK_GEN_FRAC_EN
  logic [NUM_CH*FRAC_W-1:0] cfg_frac;
`endif
  logic                     cfg_valid;
  logic                     cfg_ready;

  modport master (
    output cfg_div,
`ifdef CLK_GEN_FRAC_EN
    output cfg_frac,
`endif
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_div,
`ifdef CLK_GEN_FRAC_EN
    input  cfg_frac,
`endif
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel programmable clock-enable generator
// CLK_GEN_FRAC_EN enables fractional divide (D + frac/2^FRAC_W).
module clk_en_gen #(
  parameter int CNT_W       = 16,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 2000,
  parameter int FRAC_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  clk_en_gen_if.slave       cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  if (NUM_CH < 1 || CNT_W < 1 || FRAC_W < 1) begin : g_bad_params
    $error("clk_en_gen: NUM_CH, CNT_W and FRAC_W must be at least 1");
  end

  logic              xfer;
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  div_act[NUM_CH];
  logic [CNT_W-1:0]  div_sh [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] halted;

`ifdef CLK_GEN_FRAC_EN
  logic [FRAC_W-1:0] frac_act[NUM_CH];
  logic [FRAC_W-1:0] frac_sh [NUM_CH];
  logic [FRAC_W-1:0] acc     [NUM_CH];
  logic [FRAC_W:0]   acc_sum [NUM_CH];
  logic [NUM_CH-1:0] stretch;
`endif

  assign xfer = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      halted[i] = (div_act[i] == '0);
`ifdef CLK_GEN_FRAC_EN
      // A carried period runs one extra cycle: compare against D instead of D-1.
      wrap[i] = en && !halted[i] &&
                (cnt[i] == div_act[i] - {{(CNT_W-1){1'b0}}, ~stretch[i]});
`else
      wrap[i] = en && !halted[i] && (cnt[i] == div_act[i] - 1'b1);
`endif
      apply[i] = pend[i] && (wrap[i] || (en && halted[i]));
`ifdef CLK_GEN_FRAC_EN
      acc_sum[i] = {1'b0, acc[i]} + {1'b0, (apply[i] ? frac_sh[i] : frac_act[i])};
`endif
    end
    // Pending is all-clear whenever a transfer is accepted, so xfer and apply never overlap.
    pend_nxt = xfer ? {NUM_CH{1'b1}} : (pend & ~apply);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= CNT_W'(DEFAULT_DIV);
        div_sh[i]  <= '0;
`ifdef CLK_GEN_FRAC_EN
        frac_act[i] <= '0;
        frac_sh[i]  <= '0;
        acc[i]      <= '0;
`endif
      end
`ifdef CLK_GEN_FRAC_EN
      stretch <= '0;
`endif
      pend          <= '0;
      tick          <= '0;
      clk_out       <= '0;
      cfg.cfg_ready <= 1'b1;
    end else if (sync) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        if (xfer) begin
          div_act[i] <= cfg.cfg_div[i*CNT_W +: CNT_W];
          div_sh[i]  <= cfg.cfg_div[i*CNT_W +: CNT_W];
        end else if (pend[i]) begin
          div_act[i] <= div_sh[i];
        end
`ifdef CLK_GEN_FRAC_EN
        if (xfer) begin
          frac_act[i] <= cfg.cfg_frac[i*FRAC_W +: FRAC_W];
          frac_sh[i]  <= cfg.cfg_frac[i*FRAC_W +: FRAC_W];
        end else if (pend[i]) begin
          frac_act[i] <= frac_sh[i];
        end
        acc[i] <= '0;
`endif
      end
`ifdef CLK_GEN_FRAC_EN
      stretch <= '0;
`endif
      pend          <= '0;
      tick          <= '0;
      clk_out       <= '0;
      cfg.cfg_ready <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (xfer) begin
          div_sh[i] <= cfg.cfg_div[i*CNT_W +: CNT_W];
        end
        if (apply[i]) begin
          div_act[i] <= div_sh[i];
        end
`ifdef CLK_GEN_FRAC_EN
        if (xfer) begin
          frac_sh[i] <= cfg.cfg_frac[i*FRAC_W +: FRAC_W];
        end
        if (apply[i]) begin
          frac_act[i] <= frac_sh[i];
        end
        if (wrap[i]) begin
          acc[i]     <= acc_sum[i][FRAC_W-1:0];
          stretch[i] <= acc_sum[i][FRAC_W];
        end
`endif
        if (wrap[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
        end else if (en && !halted[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        tick[i] <= wrap[i];
      end
      pend          <= pend_nxt;
      cfg.cfg_ready <= ~|pend_nxt;
    end
  end

endmodule
